fp_round_stage: RTL and testbench

- Pipelined rounding and packing stage directly downstream of the normalizer in fp_adder, fp_sub, fp_madd and fp_msub.
- Consumes the normalizer's extended mantissa (mantissa[26:3], guard, round and sticky in bits 2, 1 and 0) and its adjusted exponent.
- Applies the IEEE 754 rounding mode, handles carry-out, overflow and subnormal promotion, and packs a single-precision result.
- Two register stages with valid/ready flow control on both sides.

---
 rtl/fp_round_stage.sv | 181 ++++++++++++++++++
 tb/tb_fp_round_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_stage.sv
// fp_round_stage: two-stage rounding and packing stage after the FP normalizer.
//   Stage 1 decides the round increment from the rounding mode and the G/R/S bits.
//   Stage 2 applies it, handles carry-out, subnormal promotion and overflow,
//   and packs a sign/exponent/fraction word (or forwards a pre-formed special value).
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready    upstream handshake
//   in_sign, in_mantissa_ext ([FRAC_W+3:3] mantissa incl. hidden bit, [2:0] G/R/S),
//   in_exponent, in_special, in_special_val, rnd_mode (sampled with in_valid)
//   out_valid / out_ready  downstream handshake
//   out_result             packed result
// Optional (macro FP_ROUND_FLAGS_EN): flag_inexact, flag_overflow, flag_underflow,
//   registered alongside out_result.
module fp_round_stage #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [FRAC_W+3:0]       in_mantissa_ext,
  input  logic [EXP_W-1:0]        in_exponent,
  input  logic                    in_special,
  input  logic [EXP_W+FRAC_W:0]   in_special_val,
  input  logic [1:0]              rnd_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result
`ifdef FP_ROUND_FLAGS_EN
  ,
  output logic                    flag_inexact,
  output logic                    flag_overflow,
  output logic                    flag_underflow
`endif
);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  // Stage 1 registers
  logic                  s1_valid_q;
  logic [FRAC_W:0]       s1_mant_q;
  logic [EXP_W:0]        s1_exp_q;
  logic                  s1_sign_q;
  logic                  s1_inc_q;
  logic [1:0]            s1_rm_q;
  logic                  s1_special_q;
  logic [EXP_W+FRAC_W:0] s1_special_val_q;
`ifdef FP_ROUND_FLAGS_EN
  logic                  s1_inexact_q;
  logic                  flag_inexact_q, flag_overflow_q, flag_underflow_q;
  logic                  flag_inexact_d, flag_overflow_d, flag_underflow_d;
`endif

  // Output (stage 2) registers
  logic                  out_valid_q;
  logic [EXP_W+FRAC_W:0] out_result_q;
  logic [EXP_W+FRAC_W:0] out_result_d;

  logic s1_adv, s2_adv, in_fire;
  logic inc_d, any_grs;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // Stage 1: round-increment decision
  always_comb begin
    any_grs = |in_mantissa_ext[2:0];
    inc_d   = 1'b0;
    case (rnd_mode)
      RM_RNE:  inc_d = in_mantissa_ext[2] & (in_mantissa_ext[1] | in_mantissa_ext[0] | in_mantissa_ext[3]);
      RM_RTZ:  inc_d = 1'b0;
      RM_RUP:  inc_d = !in_sign & any_grs;
      RM_RDN:  inc_d = in_sign & any_grs;
      default: inc_d = 1'b0;
    endcase
  end

  // Stage 2: apply increment and pack
  logic [FRAC_W+1:0] sum;
  logic [FRAC_W-1:0] frac;
  logic [EXP_W:0]    exp_fin;
  logic              ovf, to_inf;

  always_comb begin
    sum     = {1'b0, s1_mant_q} + {{(FRAC_W+1){1'b0}}, s1_inc_q};
    frac    = sum[FRAC_W-1:0];
    exp_fin = s1_exp_q;
    if (sum[FRAC_W+1]) begin
      frac    = sum[FRAC_W:1];
      exp_fin = s1_exp_q + EXP_ONE;
    end else if (s1_exp_q == '0 && sum[FRAC_W]) begin
      // rounding pushed a subnormal up into the smallest normal binade
      exp_fin = EXP_ONE;
    end
    ovf    = exp_fin >= EXP_MAX;
    to_inf = (s1_rm_q == RM_RNE) || (s1_rm_q == RM_RUP && !s1_sign_q) ||
             (s1_rm_q == RM_RDN && s1_sign_q);

    if (s1_special_q)
      out_result_d = s1_special_val_q;
    else if (ovf)
      out_result_d = to_inf ? {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                            : {s1_sign_q, {{(EXP_W-1){1'b1}}, 1'b0}, {FRAC_W{1'b1}}};
    else if (sum == '0)
      out_result_d = {s1_sign_q, {(EXP_W+FRAC_W){1'b0}}};
    else
      out_result_d = {s1_sign_q, exp_fin[EXP_W-1:0], frac};

`ifdef FP_ROUND_FLAGS_EN
    flag_overflow_d  = !s1_special_q && ovf;
    flag_inexact_d   = !s1_special_q && (s1_inexact_q || ovf);
    flag_underflow_d = !s1_special_q && !ovf && s1_inexact_q &&
                       (out_result_d[EXP_W+FRAC_W-1:FRAC_W] == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q       <= 1'b0;
      s1_mant_q        <= '0;
      s1_exp_q         <= '0;
      s1_sign_q        <= 1'b0;
      s1_inc_q         <= 1'b0;
      s1_rm_q          <= '0;
      s1_special_q     <= 1'b0;
      s1_special_val_q <= '0;
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
`ifdef FP_ROUND_FLAGS_EN
      s1_inexact_q     <= 1'b0;
      flag_inexact_q   <= 1'b0;
      flag_overflow_q  <= 1'b0;
      flag_underflow_q <= 1'b0;
`endif
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_mant_q        <= in_mantissa_ext[FRAC_W+3:3];
        s1_exp_q         <= {1'b0, in_exponent};
        s1_sign_q        <= in_sign;
        s1_inc_q         <= inc_d;
        s1_rm_q          <= rnd_mode;
        s1_special_q     <= in_special;
        s1_special_val_q <= in_special_val;
`ifdef FP_ROUND_FLAGS_EN
        s1_inexact_q     <= any_grs;
`endif
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_result_q     <= out_result_d;
`ifdef FP_ROUND_FLAGS_EN
          flag_inexact_q   <= flag_inexact_d;
          flag_overflow_q  <= flag_overflow_d;
          flag_underflow_q <= flag_underflow_d;
`endif
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
`ifdef FP_ROUND_FLAGS_EN
  assign flag_inexact   = flag_inexact_q;
  assign flag_overflow  = flag_overflow_q;
  assign flag_underflow = flag_underflow_q;
`endif

endmodule

// File: tb/tb_fp_round_stage.sv
// Self-checking bench for fp_round_stage: directed vectors pushed to a scoreboard
// when accepted, compared in order when the result handshake completes.
module tb_fp_round_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_special;
  logic [26:0] in_mantissa_ext;
  logic [7:0]  in_exponent;
  logic [31:0] in_special_val;
  logic [1:0]  rnd_mode;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
`ifdef FP_ROUND_FLAGS_EN
  logic        flag_inexact, flag_overflow, flag_underflow;
`endif

  fp_round_stage #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_mantissa_ext(in_mantissa_ext), .in_exponent(in_exponent),
    .in_special(in_special), .in_special_val(in_special_val), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
`ifdef FP_ROUND_FLAGS_EN
    , .flag_inexact(flag_inexact), .flag_overflow(flag_overflow), .flag_underflow(flag_underflow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        sgn;
    logic [26:0] m;
    logic [7:0]  e;
    logic [1:0]  rm;
    logic        sp;
    logic [31:0] sv;
    logic [31:0] res;
    logic [2:0]  fl;   // {inexact, overflow, underflow}
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  fl;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[16];
  int   n_acc = 0;

  // Inputs are changed only #1 after a rising edge, so in_ready sampled on the
  // falling edge is what the DUT sees at the next rising edge.
  task automatic send(input vec_t v, input bit lat);
    exp_t e;
    bit   ok;
    in_valid        = 1'b1;
    in_sign         = v.sgn;
    in_mantissa_ext = v.m;
    in_exponent     = v.e;
    rnd_mode        = v.rm;
    in_special      = v.sp;
    in_special_val  = v.sv;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      e.res = v.res; e.fl = v.fl; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
      n_acc++;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: in-order compare, latency, and hold stability under stall.
  logic        held_v = 1'b0;
  logic [31:0] held_r;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) check_eq("hold_stable", 64'(out_result), 64'(held_r));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check_eq("result", 64'(out_result), 64'(e.res));
`ifdef FP_ROUND_FLAGS_EN
          check_eq("flags", 64'({flag_inexact, flag_overflow, flag_underflow}), 64'(e.fl));
`endif
          if (e.lat) check_eq("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
      held_v = out_valid && !out_ready;
      held_r = out_result;
    end
  end

  initial begin
    vt[0]  = '{1'b0, {24'h800000, 3'b000}, 8'd127, 2'b00, 1'b0, 32'h0, 32'h3F800000, 3'b000};
    vt[1]  = '{1'b0, {24'h800001, 3'b100}, 8'd127, 2'b00, 1'b0, 32'h0, 32'h3F800002, 3'b100};
    vt[2]  = '{1'b0, {24'h800000, 3'b100}, 8'd127, 2'b00, 1'b0, 32'h0, 32'h3F800000, 3'b100};
    vt[3]  = '{1'b0, {24'hFFFFFF, 3'b110}, 8'd127, 2'b00, 1'b0, 32'h0, 32'h40000000, 3'b100};
    vt[4]  = '{1'b0, {24'hFFFFFF, 3'b100}, 8'd254, 2'b00, 1'b0, 32'h0, 32'h7F800000, 3'b110};
    vt[5]  = '{1'b0, {24'hFFFFFF, 3'b100}, 8'd254, 2'b01, 1'b0, 32'h0, 32'h7F7FFFFF, 3'b100};
    vt[6]  = '{1'b1, {24'hFFFFFF, 3'b100}, 8'd254, 2'b10, 1'b0, 32'h0, 32'hFF7FFFFF, 3'b100};
    vt[7]  = '{1'b0, {24'h7FFFFF, 3'b100}, 8'd0,   2'b00, 1'b0, 32'h0, 32'h00800000, 3'b100};
    vt[8]  = '{1'b0, {24'h000001, 3'b010}, 8'd0,   2'b00, 1'b0, 32'h0, 32'h00000001, 3'b101};
    vt[9]  = '{1'b0, {24'h800000, 3'b001}, 8'd127, 2'b10, 1'b0, 32'h0, 32'h3F800001, 3'b100};
    vt[10] = '{1'b1, {24'h800000, 3'b001}, 8'd127, 2'b11, 1'b0, 32'h0, 32'hBF800001, 3'b100};
    vt[11] = '{1'b0, {24'h800000, 3'b001}, 8'd127, 2'b11, 1'b0, 32'h0, 32'h3F800000, 3'b100};
    vt[12] = '{1'b1, {24'h800000, 3'b111}, 8'd127, 2'b01, 1'b0, 32'h0, 32'hBF800000, 3'b100};
    vt[13] = '{1'b0, {24'hFFFFFF, 3'b111}, 8'd200, 2'b00, 1'b1, 32'h7FC00000, 32'h7FC00000, 3'b000};
    vt[14] = '{1'b0, {24'h800000, 3'b000}, 8'd255, 2'b00, 1'b0, 32'h0, 32'h7F800000, 3'b110};
    vt[15] = '{1'b1, {24'h000000, 3'b000}, 8'd0,   2'b00, 1'b0, 32'h0, 32'h80000000, 3'b000};

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_special = 1'b0;
    in_mantissa_ext = '0; in_exponent = '0; in_special_val = '0; rnd_mode = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_result", 64'(out_result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed vectors, back to back, no stall
    for (int i = 0; i < 16; i++) send(vt[i], i == 0);
    drain();

    // Backpressure: three back-to-back inputs with the output stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    begin
      int base;
      base = n_acc;
      fork
        begin
          send(vt[0], 1'b0);
          send(vt[1], 1'b0);
          send(vt[3], 1'b0);
        end
        begin
          repeat (6) @(negedge clk);
          check_eq("bp_accepts", 64'(n_acc - base), 64'd2);
          check_eq("bp_in_ready", 64'(in_ready), 64'd0);
          check_eq("bp_out_valid", 64'(out_valid), 64'd1);
          @(posedge clk); #1;
          out_ready = 1'b1;
        end
      join
    end
    drain();

    // Reset in mid-stream discards everything in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(vt[4], 1'b0);
    send(vt[7], 1'b0);
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid", 64'(out_valid), 64'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("no_stale_out", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(vt[8], 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
